aes_spi_master: RTL and testbench
=================================

AES_SPI_MASTER -- requirements
Module: aes_spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 4, number of clk cycles per sck phase (high or low); legal range 2..255.
REQ-002 Parameter: TIMEOUT_CYCLES, default 65535, maximum clk cycles spent waiting for slave completion.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  command request; sampled on the clk rising edge.
REQ-006 mode  input  1  1 = encrypt, 0 = decrypt.
REQ-007 usr_key  input  128  AES key.
REQ-008 usr_addr  input  8  SRAM start address.
REQ-009 usr_loc  input  8  block count.
REQ-010 busy  output  1  high from command acceptance until completion or timeout.
REQ-011 cmd_done  output  1  one-cycle pulse when the slave reports completion.
REQ-012 timeout  output  1  one-cycle pulse when the completion wait expires.
REQ-013 sck  output  1  SPI clock, mode 0 (idle low).
REQ-014 ss  output  1  active-low slave select.
REQ-015 mosi  output  1  serial data to the slave, MSB first.
REQ-016 miso  input  1  slave completion line, asynchronous to clk.

Function
REQ-017 Frame is 152 bits, transmitted MSB first: {mode, 7'b0, usr_key[127:0], usr_addr, usr_loc}.
REQ-018 FSM states: IDLE, SETUP, SHIFT, GAP, WAIT_DONE.
REQ-019 In IDLE, start=1 latches the frame into a 152-bit shift register on the same edge; next state is SETUP; busy=1 from the next cycle.
REQ-020 start while busy=1 is ignored; inputs are not re-sampled.
REQ-021 SETUP: ss=0, sck=0, mosi=frame[151] for CLK_DIV cycles, then SHIFT.
REQ-022 SHIFT: each bit is sck=1 for CLK_DIV cycles, then sck=0 for CLK_DIV cycles; on each sck high-to-low transition the register shifts left and mosi presents the next bit; mosi is stable through every sck rising edge.
REQ-023 A bit counter counts sck rising edges; after the high phase of bit 152, sck=0 and the FSM enters GAP.
REQ-024 GAP: ss=0, sck=0 for CLK_DIV cycles, then ss=1 and the FSM enters WAIT_DONE.
REQ-025 Total ss-low time is exactly 305*CLK_DIV cycles; exactly 152 sck rising edges occur per frame.
REQ-026 miso passes through a 2-flop synchronizer; a synchronized 0-to-1 transition in WAIT_DONE is the completion event; miso is ignored in all other states.
REQ-027 On completion: cmd_done=1 for one cycle, busy=0 on the same edge, and the FSM returns to IDLE.
REQ-028 A wait counter cleared on WAIT_DONE entry increments each cycle; when it reaches TIMEOUT_CYCLES: timeout=1 for one cycle, busy=0, and the FSM returns to IDLE.
REQ-029 If completion and timeout occur in the same cycle, completion wins: cmd_done=1, timeout=0.
REQ-030 start in the same cycle as cmd_done or timeout is ignored; a new command is accepted only in IDLE on a following cycle.
REQ-031 Outside a frame: sck=0, ss=1, mosi=0.

Reset
REQ-032 n_rst=0 asynchronously forces state=IDLE, ss=1, sck=0, mosi=0, busy=0, cmd_done=0, timeout=0, and clears all counters, the shift register and the synchronizer.
REQ-033 Reset mid-frame aborts immediately (ss high without waiting for a clk edge); no cmd_done or timeout pulse is produced.

Structure
REQ-034 Shared package aes_spi_pkg holds FRAME_BITS=152, the FSM state enum and the header-byte layout (mode bit position), for use by both this master and the slave.
REQ-035 One sub-module, spi_clk_div: a CLK_DIV phase counter producing a one-cycle phase-end strobe, enabled only in SETUP, SHIFT and GAP.

Verification
REQ-036 Reset: assert n_rst=0 mid-SHIFT -> ss=1, sck=0, busy=0 immediately; no pulse after release.
REQ-037 Encrypt frame, CLK_DIV=4: mode=1, key=128'h000102...0F, addr=8'h10, loc=8'h04 -> a slave model captures 152 bits equal to {8'h80, key, 8'h10, 8'h04}; 152 rising edges; ss low for 1220 cycles.
REQ-038 Completion: miso rises 50 cycles after ss deasserts -> cmd_done pulses once within 3-4 cycles; busy falls on the same edge.
REQ-039 Timeout: TIMEOUT_CYCLES=100, miso held 0 -> timeout pulses exactly 100 cycles after WAIT_DONE entry; cmd_done stays 0.
REQ-040 Busy rejection: start held high for an entire command -> exactly one frame; a second frame begins only after busy falls.
REQ-041 Spurious miso: miso toggled during SHIFT -> no cmd_done; frame contents unaffected.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI command link (master and slave).
// Frame size, FSM state encoding, header layout and a frame builder.
package aes_spi_pkg;

  localparam int FRAME_BITS = 152;
  localparam int MODE_BIT   = FRAME_BITS - 1;
  localparam int HDR_PAD    = 7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    WAIT_DONE
  } state_e;

  // Header byte is {mode, 7'b0}; mode sits at MODE_BIT.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic         mode,
    input logic [127:0] key,
    input logic [7:0]   addr,
    input logic [7:0]   loc
  );
    return {mode, HDR_PAD'(0), key, addr, loc};
  endfunction

endpackage

// File: rtl/aes_spi_master_clk_div.sv
// Phase counter for the SPI master: strobes phase_end once every
// CLK_DIV enabled cycles; held at zero while en is low.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase_end
);

  logic [7:0] cnt_q, cnt_d;

  assign phase_end = en && (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = 8'd0;
    if (en && !phase_end) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aes_spi_master.sv
// SPI mode-0 master sending a 152-bit AES command frame, then waiting
// for a rising edge on miso (done) or a cycle-count timeout.
// Ports: clk, n_rst, start/mode/usr_key/usr_addr/usr_loc command in;
// busy/cmd_done/timeout status out; sck/ss/mosi/miso SPI lines.
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         mode,
  input  logic [127:0] usr_key,
  input  logic [7:0]   usr_addr,
  input  logic [7:0]   usr_loc,
  output logic         busy,
  output logic         cmd_done,
  output logic         timeout,
  output logic         sck,
  output logic         ss,
  output logic         mosi,
  input  logic         miso
);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]            bit_cnt_q, bit_cnt_d;
  logic [31:0]           wait_cnt_q, wait_cnt_d;
  logic                  sck_q, sck_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tmo_q, tmo_d;
  logic [2:0]            sync_q, sync_d;
  logic                  in_frame;
  logic                  phase_end;
  logic                  miso_rise;

  assign in_frame = (state_q == SETUP) ||
                    (state_q == SHIFT) ||
                    (state_q == GAP);

  // ss/mosi decode straight from state so reset lifts ss at once.
  assign ss       = ~in_frame;
  assign sck      = sck_q;
  assign mosi     = in_frame & shreg_q[FRAME_BITS-1];
  assign busy     = busy_q;
  assign cmd_done = done_q;
  assign timeout  = tmo_q;

  // sync_q[1:0] is the synchronizer, sync_q[2] the edge history.
  assign sync_d    = {sync_q[1:0], miso};
  assign miso_rise = sync_q[1] & ~sync_q[2];

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk       (clk),
    .rst_n     (n_rst),
    .en        (in_frame),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    sck_d      = sck_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No accept in the pulse cycle that ends a command.
        if (start && !done_q && !tmo_q) begin
          shreg_d   = build_frame(mode, usr_key, usr_addr, usr_loc);
          bit_cnt_d = 8'd0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          sck_d     = 1'b1;
          bit_cnt_d = bit_cnt_q + 8'd1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_cnt_q == 8'(FRAME_BITS)) state_d = GAP;
            else shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end else begin
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (phase_end) begin
          wait_cnt_d = 32'd0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        if (miso_rise) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= 8'd0;
      wait_cnt_q <= 32'd0;
      sck_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      sync_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      sck_q      <= sck_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      sync_q     <= sync_d;
    end
  end

endmodule

// File: tb/tb_aes_spi_master.sv
// Scoreboard bench for aes_spi_master: frame and completion monitors
// pop expectations queued by the directed stimulus.
module tb_aes_spi_master;

  localparam int CLK_DIV = 4;
  localparam int TMO     = 100;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] usr_key = '0;
  logic [7:0]   usr_addr = '0;
  logic [7:0]   usr_loc = '0;
  logic         miso = 1'b0;
  logic         busy, cmd_done, timeout, sck, ss, mosi;

  aes_spi_master #(
    .CLK_DIV        (CLK_DIV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .mode     (mode),
    .usr_key  (usr_key),
    .usr_addr (usr_addr),
    .usr_loc  (usr_loc),
    .busy     (busy),
    .cmd_done (cmd_done),
    .timeout  (timeout),
    .sck      (sck),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int frames_seen = 0;
  int pulse_cnt = 0;
  int ss_rise_cyc = 0;
  int miso_rise_cyc = 0;

  logic [151:0] exp_frame_q[$];
  int           exp_evt_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_v(input string nm, input logic [151:0] act,
                       input logic [151:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Frame monitor: acts as the slave's shift register.
  initial begin : frame_mon
    logic [151:0] bits;
    int           edges;
    int           low_cyc;
    bit           in_frame;
    bit           prev_sck;
    bit           prev_ss;
    bits = '0; edges = 0; low_cyc = 0;
    in_frame = 0; prev_sck = 0; prev_ss = 1;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        in_frame = 0; prev_sck = 0; prev_ss = 1;
      end else begin
        if (!ss) begin
          if (prev_ss) begin
            in_frame = 1; bits = '0; edges = 0; low_cyc = 0;
          end
          low_cyc++;
          if (sck && !prev_sck) begin
            bits = {bits[150:0], mosi};
            edges++;
          end
        end else if (!prev_ss && in_frame) begin
          in_frame = 0;
          frames_seen++;
          ss_rise_cyc = cyc;
          if (exp_frame_q.size() == 0) begin
            nchk++; nfail++;
            $display("FAIL unexpected_frame: got %h", bits);
          end else begin
            chk_v("frame_bits", bits, exp_frame_q.pop_front());
          end
          chk_i("sck_edges", edges, 152);
          chk_i("ss_low_cycles", low_cyc, 305 * CLK_DIV);
          chk_b("sck_idle", sck, 1'b0);
          chk_b("mosi_idle", mosi, 1'b0);
        end
        prev_sck = sck;
        prev_ss = ss;
      end
    end
  end

  // Completion monitor: 0 = cmd_done expected, 1 = timeout expected.
  initial begin : evt_mon
    int kind;
    forever begin
      @(negedge clk);
      if (n_rst && (cmd_done || timeout)) begin
        pulse_cnt++;
        chk_b("pulse_exclusive", cmd_done & timeout, 1'b0);
        chk_b("busy_at_pulse", busy, 1'b0);
        if (exp_evt_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_pulse: got done=%b tmo=%b",
                   cmd_done, timeout);
        end else begin
          kind = exp_evt_q.pop_front();
          if (kind == 0) begin
            chk_b("evt_done", cmd_done, 1'b1);
            chk_i("done_latency", cyc - miso_rise_cyc, 3);
          end else begin
            chk_b("evt_timeout", timeout, 1'b1);
            chk_i("timeout_latency", cyc - ss_rise_cyc, TMO);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic m, input logic [127:0] k,
                      input logic [7:0] a, input logic [7:0] l,
                      input bit hold);
    @(negedge clk);
    mode = m; usr_key = k; usr_addr = a; usr_loc = l; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk_b("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_ss_high(input int max);
    int n = 0;
    while (ss !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk_b("ss_rise_in_time", ss, 1'b1);
  endtask

  task automatic wait_busy_low(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk_b("busy_fall_in_time", busy, 1'b0);
  endtask

  task automatic finish_done();
    repeat (50) @(negedge clk);
    miso = 1'b1;
    miso_rise_cyc = cyc;
    wait_busy_low(20);
    miso = 1'b0;
  endtask

  initial begin : stim
    int f0;
    int p0;
    logic [127:0] k1, k2, k3, k4;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    k2 = 128'hffeeddccbbaa99887766554433221100;
    k3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k4 = 128'h80000000000000000000000000000001;

    @(negedge clk);
    chk_b("rst_ss", ss, 1'b1);
    chk_b("rst_sck", sck, 1'b0);
    chk_b("rst_mosi", mosi, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", cmd_done, 1'b0);
    chk_b("rst_timeout", timeout, 1'b0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Encrypt frame, completion 50 cycles after ss rises.
    exp_frame_q.push_back({8'h80, k1, 8'h10, 8'h04});
    exp_evt_q.push_back(0);
    send(1'b1, k1, 8'h10, 8'h04, 1'b0);
    wait_ss_high(2000);
    finish_done();
    repeat (5) @(negedge clk);

    // Decrypt frame, miso held low -> timeout.
    exp_frame_q.push_back({8'h00, k2, 8'h3c, 8'h01});
    exp_evt_q.push_back(1);
    send(1'b0, k2, 8'h3c, 8'h01, 1'b0);
    wait_ss_high(2000);
    wait_busy_low(TMO + 10);
    repeat (5) @(negedge clk);

    // start held for a whole command; inputs changed mid-command.
    f0 = frames_seen;
    exp_frame_q.push_back({8'h80, k3, 8'ha5, 8'hff});
    exp_evt_q.push_back(0);
    send(1'b1, k3, 8'ha5, 8'hff, 1'b1);
    usr_key = k2; mode = 1'b0; usr_addr = 8'h00;
    wait_ss_high(2000);
    finish_done();
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk_b("no_restart_busy", busy, 1'b0);
    chk_b("no_restart_ss", ss, 1'b1);
    chk_i("one_frame_held_start", frames_seen - f0, 1);

    // Spurious miso toggles during SHIFT.
    p0 = pulse_cnt;
    exp_frame_q.push_back({8'h00, k4, 8'h00, 8'h80});
    exp_evt_q.push_back(0);
    send(1'b0, k4, 8'h00, 8'h80, 1'b0);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      miso = ~miso;
      repeat (7) @(negedge clk);
    end
    wait_ss_high(2000);
    chk_i("no_done_in_shift", pulse_cnt, p0);
    finish_done();
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of SHIFT.
    send(1'b1, k1, 8'h10, 8'h04, 1'b0);
    repeat (100) @(negedge clk);
    p0 = pulse_cnt;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk_b("abort_ss", ss, 1'b1);
    chk_b("abort_sck", sck, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_mosi", mosi, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (300) @(negedge clk);
    chk_i("no_pulse_after_abort", pulse_cnt, p0);
    chk_b("idle_after_abort", busy, 1'b0);
    chk_i("frames_left", exp_frame_q.size(), 0);
    chk_i("events_left", exp_evt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
